// File: rtl/gl_cmd_writer.sv
// Host-to-instruction-BRAM ring writer; only packets closed by host_last become visible to fetch.
// Optional statistics counters are enabled with `define GL_CMD_WRITER_STATS_EN.
module gl_cmd_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [31:0]   host_data,
  input  logic          host_last,
  input  logic          host_abort,
  output logic          bram_we,
  output logic [31:0]   bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   fetch_rd_addr,
  output logic [31:0]   commit_addr,
  output logic          inst_avail,
  output logic [AW:0]   occupancy,
  output logic          pkt_err
`ifdef GL_CMD_WRITER_STATS_EN
  ,
  output logic [31:0]   stat_words,
  output logic [31:0]   stat_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] commit_ptr_q, commit_ptr_d;
  logic          pkt_err_q, pkt_err_d;
  logic          bram_we_q, bram_we_d;
  logic [31:0]   bram_addr_q, bram_addr_d;
  logic [31:0]   bram_wdata_q, bram_wdata_d;
  logic [31:0]   commit_addr_q, commit_addr_d;

  logic [AW-1:0] rd_off;
  logic [AW-1:0] used;
  logic          full;
  logic          hs;

  // AW-bit arithmetic gives the mod-DEPTH wrap for free.
  assign rd_off = AW'(fetch_rd_addr - BASE_ADDR);
  assign used   = wr_ptr_q - rd_off;
  assign full   = (used == AW'(DEPTH - 1));

  assign host_ready = reset_n && !full && (state_q != COMMIT) && !host_abort;
  assign hs         = host_valid && host_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    pkt_err_d     = pkt_err_q;
    bram_we_d     = 1'b0;
    bram_addr_d   = bram_addr_q;
    bram_wdata_d  = bram_wdata_q;
    commit_addr_d = commit_addr_q;

    if (hs) begin
      bram_we_d    = 1'b1;
      bram_addr_d  = BASE_ADDR + 32'(wr_ptr_q);
      bram_wdata_d = host_data;
      wr_ptr_d     = wr_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hs) state_d = host_last ? COMMIT : FILL;
      end
      FILL: begin
        if (host_abort) begin
          wr_ptr_d = commit_ptr_q;
          state_d  = IDLE;
        end else if (full && (rd_off == commit_ptr_q)) begin
          // Ring holds only this packet and fetch is drained: it can never complete.
          pkt_err_d = 1'b1;
          wr_ptr_d  = commit_ptr_q;
          state_d   = IDLE;
        end else if (hs && host_last) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_ptr_d  = wr_ptr_q;
        commit_addr_d = BASE_ADDR + 32'(wr_ptr_q);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      pkt_err_q     <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= BASE_ADDR;
      bram_wdata_q  <= '0;
      commit_addr_q <= BASE_ADDR;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      pkt_err_q     <= pkt_err_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_wdata_q  <= bram_wdata_d;
      commit_addr_q <= commit_addr_d;
    end
  end

  assign bram_we     = bram_we_q;
  assign bram_addr   = bram_addr_q;
  assign bram_wdata  = bram_wdata_q;
  assign commit_addr = commit_addr_q;
  assign inst_avail  = (rd_off != commit_ptr_q);
  assign occupancy   = {1'b0, used};
  assign pkt_err     = pkt_err_q;

`ifdef GL_CMD_WRITER_STATS_EN
  logic [31:0]   stat_words_q, stat_words_d;
  logic [31:0]   stat_stall_q, stat_stall_d;
  logic [AW-1:0] pkt_len;
  logic [32:0]   words_sum;

  assign pkt_len   = wr_ptr_q - commit_ptr_q;
  assign words_sum = {1'b0, stat_words_q} + 33'(pkt_len);

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (state_q == COMMIT) stat_words_d = words_sum[32] ? '1 : words_sum[31:0];
    if (host_valid && !host_ready && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_gl_cmd_writer.sv
// Bench for gl_cmd_writer (DEPTH=8, BASE_ADDR=0x40): directed scenarios with literal expectations,
// then random traffic checked every cycle against a packet-queue model.
module tb_gl_cmd_writer;
  localparam int unsigned D    = 8;
  localparam int unsigned AWB  = 3;
  localparam logic [31:0] BASE = 32'h40;

  logic          clk = 1'b0;
  logic          reset_n, host_valid, host_ready, host_last, host_abort;
  logic          bram_we, inst_avail, pkt_err;
  logic [31:0]   host_data, bram_addr, bram_wdata, fetch_rd_addr, commit_addr;
  logic [AWB:0]  occupancy;
`ifdef GL_CMD_WRITER_STATS_EN
  logic [31:0]   stat_words, stat_stall;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  gl_cmd_writer #(.BASE_ADDR(BASE), .DEPTH(D), .AW(AWB)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .host_last(host_last), .host_abort(host_abort),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .fetch_rd_addr(fetch_rd_addr), .commit_addr(commit_addr),
    .inst_avail(inst_avail), .occupancy(occupancy), .pkt_err(pkt_err)
`ifdef GL_CMD_WRITER_STATS_EN
    , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: committed offset plus the words of the open packet, in order.
  int unsigned  m_cp;
  logic [31:0]  m_q[$];
  bit           m_pend, m_err;
  bit           e_we;
  logic [31:0]  e_addr, e_wdata, e_caddr;
  logic [31:0]  m_words, m_stall;

  always @(negedge clk) begin : model_p
    int unsigned rd, wr, used;
    bit rdy, fill;
    if (!reset_n) begin
      m_cp = 0; m_q.delete(); m_pend = 0; m_err = 0;
      e_we = 0; e_addr = BASE; e_wdata = 0; e_caddr = BASE;
      m_words = 0; m_stall = 0;
    end
    rd   = (fetch_rd_addr - BASE) % D;
    wr   = (m_cp + m_q.size()) % D;
    used = (wr + D - rd) % D;
    rdy  = reset_n && (used != D - 1) && !m_pend && !host_abort;

    chk("host_ready", host_ready, rdy);
    chk("bram_we", bram_we, e_we);
    if (e_we || !reset_n) begin
      chk("bram_addr", bram_addr, e_addr);
      chk("bram_wdata", bram_wdata, e_wdata);
    end
    chk("commit_addr", commit_addr, e_caddr);
    chk("inst_avail", inst_avail, rd != m_cp);
    chk("occupancy", occupancy, used);
    chk("pkt_err", pkt_err, m_err);
`ifdef GL_CMD_WRITER_STATS_EN
    chk("stat_words", stat_words, m_words);
    chk("stat_stall", stat_stall, m_stall);
`endif

    if (reset_n) begin
      e_we = 0;
      fill = (m_q.size() != 0) && !m_pend;
      if (m_pend) begin
        m_words = m_words + m_q.size();
        m_cp    = (m_cp + m_q.size()) % D;
        m_q.delete();
        m_pend  = 0;
        e_caddr = BASE + m_cp;
      end else if (fill && host_abort) begin
        m_q.delete();
      end else if (fill && used == D - 1 && rd == m_cp) begin
        m_err = 1;
        m_q.delete();
      end else if (host_valid && rdy) begin
        e_we = 1; e_addr = BASE + wr; e_wdata = host_data;
        m_q.push_back(host_data);
        if (host_last) m_pend = 1;
      end
      if (host_valid && !rdy) m_stall = m_stall + 1;
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [31:0] d, input bit lst);
    host_valid = 1; host_data = d; host_last = lst;
    cyc();
    host_valid = 0; host_last = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; host_valid = 0; host_last = 0; host_abort = 0;
    cyc(); cyc();
    reset_n = 1;
  endtask

  initial begin
    int unsigned rd;
    reset_n = 0; host_valid = 0; host_last = 0; host_abort = 0; host_data = 0;
    fetch_rd_addr = BASE;
    cyc(); #1;
    chk("rst_ready", host_ready, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, BASE);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_commit", commit_addr, BASE);
    chk("rst_err", pkt_err, 0);
    chk("rst_avail", inst_avail, 0);
    cyc(); reset_n = 1;

    // Single 4-word packet
    send(32'h101, 0);
    chk("w1_we", bram_we, 1); chk("w1_addr", bram_addr, BASE); chk("w1_data", bram_wdata, 32'h101);
    send(32'h102, 0); send(32'h103, 0); send(32'h104, 1);
    chk("w4_addr", bram_addr, BASE + 3); chk("w4_data", bram_wdata, 32'h104);
    chk("precommit", commit_addr, BASE);
    cyc(); #1;
    chk("postcommit", commit_addr, BASE + 4);
    chk("avail_pkt", inst_avail, 1);
    chk("occ_pkt", occupancy, 4);

    // Reset in the middle of a packet
    fetch_rd_addr = BASE + 4;
    send(32'h201, 0); send(32'h202, 0); send(32'h203, 0);
    fetch_rd_addr = BASE; reset_n = 0; #1;
    chk("mid_we", bram_we, 0); chk("mid_addr", bram_addr, BASE); chk("mid_wdata", bram_wdata, 0);
    chk("mid_commit", commit_addr, BASE); chk("mid_avail", inst_avail, 0);
    chk("mid_ready", host_ready, 0); chk("mid_occ", occupancy, 0);
    cyc(); reset_n = 1;

    // Fill to DEPTH-1, then wrap once fetch moves
    for (int i = 1; i <= 7; i++) send(32'h300 + i, i == 7);
    #1;
    chk("full_ready", host_ready, 0); chk("full_occ", occupancy, 7);
    cyc();
    chk("full_commit", commit_addr, BASE + 7);
    fetch_rd_addr = BASE + 3;
    send(32'h308, 0); chk("wrap_a7", bram_addr, BASE + 7);
    send(32'h309, 0); chk("wrap_a0", bram_addr, BASE);
    send(32'h30A, 1); chk("wrap_a1", bram_addr, BASE + 1); chk("wrap_d1", bram_wdata, 32'h30A);
    #1; chk("refull_ready", host_ready, 0);

    // Abort open packet
    fetch_rd_addr = BASE; do_reset();
    send(32'h401, 0); send(32'h402, 0);
    host_valid = 1; host_data = 32'h403; host_abort = 1; #1;
    chk("abort_ready", host_ready, 0);
    cyc(); host_abort = 0; host_valid = 0; #1;
    chk("abort_we", bram_we, 0); chk("abort_commit", commit_addr, BASE); chk("abort_occ", occupancy, 0);
    send(32'h501, 0); chk("reuse_a0", bram_addr, BASE);
    send(32'h502, 1); chk("reuse_a1", bram_addr, BASE + 1);
    cyc(); chk("reuse_commit", commit_addr, BASE + 2);

    // Oversize packet with fetch drained
    do_reset();
    for (int i = 1; i <= 7; i++) send(32'h600 + i, 0);
    host_valid = 1; host_data = 32'h608; #1;
    chk("ovf_ready", host_ready, 0); chk("ovf_err0", pkt_err, 0);
    cyc(); #1;
    chk("ovf_err1", pkt_err, 1); chk("ovf_commit", commit_addr, BASE); chk("ovf_occ", occupancy, 0);
    send(32'h608, 0); chk("ovf_a0", bram_addr, BASE);
    send(32'h609, 1);
    cyc(); chk("ovf_commit2", commit_addr, BASE + 2); chk("ovf_sticky", pkt_err, 1);

`ifdef GL_CMD_WRITER_STATS_EN
    do_reset();
    host_valid = 1; host_abort = 1; host_data = 32'hDEAD;
    for (int i = 0; i < 5; i++) cyc();
    host_abort = 0; host_valid = 0;
    for (int i = 1; i <= 4; i++) send(32'h700 + i, i == 4);
    cyc();
    for (int i = 1; i <= 4; i++) send(32'h710 + i, i == 4);
    cyc();
    chk("stat_words_lit", stat_words, 8);
    chk("stat_stall_lit", stat_stall, 5);
`endif

    // Random traffic
    do_reset();
    rd = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 1000 == 999) begin
        fetch_rd_addr = BASE; rd = 0;
        do_reset();
      end
      host_valid = ($urandom % 4) != 0;
      host_data  = $urandom;
      host_last  = ($urandom % ((c < 2000) ? 4 : 12)) == 0;
      host_abort = ($urandom % 24) == 0;
      if (rd != m_cp && ($urandom % 3) != 0) rd = (rd + 1) % D;
      fetch_rd_addr = BASE + rd + D * ($urandom % 4);
      cyc();
    end
    host_valid = 0; host_last = 0; host_abort = 0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
